// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: latches a parallel word and shifts it out MSB-first,
// holding each bit for DIV clock cycles, with bit-valid, busy and done indications.
module serial_pattern_tx #(
  parameter int DATA_W = 8,
  parameter int DIV    = 50_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         sw,
  input  logic                      start,
  input  logic                      repeat_en,
  output logic                      serial_out,
  output logic                      bit_valid,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(DATA_W)-1:0] bit_idx
);

  localparam int IW = $clog2(DATA_W);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MSB    = IW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [PW-1:0]     r_presc;
  logic [IW-1:0]     r_idx;
  logic              r_startQ;
  logic              r_seenLow;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic w_startPulse;
  logic w_bitEnd;

  // r_seenLow blocks the false edge a start held high through reset release would create.
  assign w_startPulse = start & ~r_startQ & r_seenLow;
  assign w_bitEnd     = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_presc   <= '0;
      r_idx     <= '0;
      r_startQ  <= 1'b0;
      r_seenLow <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_startQ <= start;
      if (!start) begin
        r_seenLow <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_startPulse) begin
            r_shift <= sw;
            r_idx   <= IDX_MSB;
            r_presc <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_bitEnd) begin
            r_presc <= '0;
            if (r_idx != '0) begin
              r_shift <= r_shift << 1;
              r_idx   <= r_idx - 1'b1;
            end else begin
              // Clearing the shift register also forces serial_out low in DONE.
              r_shift <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        DONE: begin
          r_done <= 1'b0;
          if (repeat_en) begin
            r_shift <= sw;
            r_idx   <= IDX_MSB;
            r_presc <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign serial_out = r_shift[DATA_W-1];
  assign bit_valid  = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign bit_idx    = r_idx;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: three instances (DIV=4, 1, 3) checked cycle by cycle
// against an expected-output queue filled when each frame is requested.
module tb_serial_pattern_tx;

  logic       clock;
  logic       rstN;
  logic [7:0] swArr   [3];
  logic       startArr[3];
  logic       repArr  [3];
  logic       soArr   [3];
  logic       bvArr   [3];
  logic       busyArr [3];
  logic       doneArr [3];
  logic [2:0] idxArr  [3];

  logic [6:0] expQ[$];
  int         checks;
  int         errors;

  serial_pattern_tx #(.DATA_W(8), .DIV(4)) u_div4 (
    .clk(clock), .reset(rstN), .sw(swArr[0]), .start(startArr[0]), .repeat_en(repArr[0]),
    .serial_out(soArr[0]), .bit_valid(bvArr[0]), .busy(busyArr[0]), .done(doneArr[0]),
    .bit_idx(idxArr[0])
  );

  serial_pattern_tx #(.DATA_W(8), .DIV(1)) u_div1 (
    .clk(clock), .reset(rstN), .sw(swArr[1]), .start(startArr[1]), .repeat_en(repArr[1]),
    .serial_out(soArr[1]), .bit_valid(bvArr[1]), .busy(busyArr[1]), .done(doneArr[1]),
    .bit_idx(idxArr[1])
  );

  serial_pattern_tx #(.DATA_W(8), .DIV(3)) u_div3 (
    .clk(clock), .reset(rstN), .sw(swArr[2]), .start(startArr[2]), .repeat_en(repArr[2]),
    .serial_out(soArr[2]), .bit_valid(bvArr[2]), .busy(busyArr[2]), .done(doneArr[2]),
    .bit_idx(idxArr[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] observed(input int k);
    return {soArr[k], bvArr[k], busyArr[k], doneArr[k], idxArr[k]};
  endfunction

  task automatic checkOutput(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed={so,bv,busy,done,idx}=%b required=%b", tag, obs, exp);
    end
  endtask

  // Expected output per cycle: each bit MSB-first held div cycles, then one done cycle.
  task automatic pushFrame(input logic [7:0] word, input int div);
    for (int i = 7; i >= 0; i--) begin
      for (int r = 0; r < div; r++) begin
        expQ.push_back({word[i], 1'b1, 1'b1, 1'b0, 3'(i)});
      end
    end
    expQ.push_back(7'b000_1_000);
  endtask

  task automatic pushIdle(input int n);
    for (int i = 0; i < n; i++) expQ.push_back(7'b0);
  endtask

  task automatic applyStimulus(input int k, input logic [7:0] word);
    swArr[k]    = word;
    startArr[k] = 1'b1;
  endtask

  task automatic disturb(input int mode, input int c);
    if (mode == 1) begin
      if (c == 4)  startArr[0] = 1'b0;
      if (c == 5)  begin startArr[0] = 1'b1; swArr[0] = 8'h00; end
      if (c == 19) startArr[0] = 1'b0;
      if (c == 20) startArr[0] = 1'b1;
    end else if (mode == 2) begin
      if (c == 22) repArr[1] = 1'b0;
    end
  endtask

  task automatic drainCheck(input int k, input string tag, input int maxCount, input int mode);
    logic [6:0] exp;
    for (int c = 1; expQ.size() > 0 && c <= maxCount; c++) begin
      @(negedge clock);
      exp = expQ.pop_front();
      checkOutput($sformatf("%s[%0d]", tag, c), observed(k), exp);
      disturb(mode, c);
    end
    expQ.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstN   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      swArr[k]    = 8'h00;
      startArr[k] = 1'b0;
      repArr[k]   = 1'b0;
    end
    startArr[0] = 1'b1;

    repeat (3) @(negedge clock);
    checkOutput("resetState", observed(0), 7'b0);
    rstN = 1'b1;

    $display("[TB] start held through reset release");
    pushIdle(100);
    drainCheck(0, "noStartAfterReset", 1000, 0);
    startArr[0] = 1'b0;
    pushIdle(1);
    drainCheck(0, "startLow", 1000, 0);

    $display("[TB] DIV=4 frame A5, start left high");
    applyStimulus(0, 8'hA5);
    pushFrame(8'hA5, 4);
    pushIdle(5);
    drainCheck(0, "frameA5", 1000, 0);
    startArr[0] = 1'b0;
    pushIdle(1);
    drainCheck(0, "idleA", 1000, 0);

    $display("[TB] DIV=4 frame A5 with sw change and extra start edges");
    applyStimulus(0, 8'hA5);
    pushFrame(8'hA5, 4);
    pushIdle(5);
    drainCheck(0, "ignoreInputs", 1000, 1);
    startArr[0] = 1'b0;

    $display("[TB] DIV=1 frame 81 with repeat");
    repArr[1] = 1'b1;
    applyStimulus(1, 8'h81);
    pushFrame(8'h81, 1);
    pushFrame(8'h81, 1);
    pushFrame(8'h81, 1);
    pushIdle(4);
    drainCheck(1, "repeat81", 1000, 2);
    startArr[1] = 1'b0;

    $display("[TB] DIV=4 frame FF with reset mid-frame");
    @(negedge clock);
    applyStimulus(0, 8'hFF);
    pushFrame(8'hFF, 4);
    drainCheck(0, "preReset", 9, 0);
    @(posedge clock);
    #2 rstN = 1'b0;
    #1 checkOutput("asyncReset", observed(0), 7'b0);
    pushIdle(3);
    drainCheck(0, "inReset", 1000, 0);
    rstN = 1'b1;
    pushIdle(6);
    drainCheck(0, "afterReset", 1000, 0);
    startArr[0] = 1'b0;
    pushIdle(1);
    drainCheck(0, "startLowB", 1000, 0);
    applyStimulus(0, 8'hFF);
    pushFrame(8'hFF, 4);
    pushIdle(3);
    drainCheck(0, "frameFF", 1000, 0);
    startArr[0] = 1'b0;

    $display("[TB] DIV=3 frame 01");
    @(negedge clock);
    applyStimulus(2, 8'h01);
    pushFrame(8'h01, 3);
    pushIdle(4);
    drainCheck(2, "frame01", 1000, 0);
    startArr[2] = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Transmit-side counterpart to the board-level sequence-detecting FSMs.
- Latches an 8-bit switch word and shifts it out MSB-first as a timed serial bit stream, with bit-valid, busy and done indications.
- Drives a detector FSM on the same board, or LEDs/PMOD pins for observation.
- Runs on the single system clock and times each bit with an internal prescaler, so no separate divided clock is needed.

Parameters:
- DATA_W, 8, width of the latched word and number of bits per frame (≥2).
- DIV, 50_000_000, clock cycles each bit is held (≥1; 0 illegal). Benches use small values.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- sw  input  DATA_W  parallel word to transmit; sampled only at frame load.
- start  input  1  frame request; already synchronous to clk; rising edge triggers.
- repeat_en  input  1  when 1 at frame end, reload sw and transmit again.
- serial_out  output  1  current bit, MSB first.
- bit_valid  output  1  1 while serial_out carries a frame bit.
- busy  output  1  1 from frame load until done.
- done  output  1  one-cycle pulse after the last bit.
- bit_idx  output  $clog2(DATA_W)  index of the bit currently on serial_out.

Behaviour:
- Reset (reset=0, asynchronous), held until release:
  - State IDLE.
  - serial_out, bit_valid, busy, done, bit_idx, prescaler, shift register = 0.
  - start history flop = 0.
- Edge detect: start_q registers start each cycle; start_pulse = start & ~start_q.
  - start held high through reset release does not trigger a frame.
  - start held high afterwards produces exactly one pulse.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - Outputs 0.
  - On the edge where start_pulse=1: shift register ← sw, bit_idx ← DATA_W-1, prescaler ← 0, state ← SHIFT.
  - serial_out = sw[DATA_W-1] and bit_valid = busy = 1 from that edge onward. Latency is one edge from the start sample.
- SHIFT:
  - The prescaler increments each cycle.
  - When prescaler == DIV-1 and bit_idx != 0: shift left one position, bit_idx decrements, prescaler ← 0.
  - When prescaler == DIV-1 and bit_idx == 0: state ← DONE, serial_out ← 0, bit_valid ← 0, busy ← 0, done ← 1.
  - Each bit is stable for exactly DIV cycles. A frame occupies DATA_W·DIV cycles.
- DONE:
  - Lasts exactly one cycle with done=1.
  - Next state: if repeat_en=1, reload sw and enter SHIFT as from IDLE (frame gap = 1 cycle). Otherwise go to IDLE.
- Ignored inputs during SHIFT/DONE:
  - start edges are discarded, not queued.
  - sw changes have no effect until the next load.
- DIV=1: one bit per cycle. The prescaler compare is always true.
- Reset asserted mid-frame: outputs drop to 0 immediately (asynchronous). No done pulse is issued. After release, a new rising start edge is required.
- repeat_en is sampled only in DONE. Deasserting it mid-frame finishes the current frame normally.

Test Plan:
- Reset with start=1, then release -> no frame. Outputs stay 0 for 100 cycles until start toggles 0→1.
- DIV=4, sw=8'hA5, start pulse -> serial_out sequence 1,0,1,0,0,1,0,1, each held 4 cycles.
  - bit_valid=busy=1 for 32 cycles; bit_idx 7→0.
  - done=1 on cycle 33 only; then IDLE.
- DIV=4, sw=8'hA5 at load, sw changed to 8'h00 and extra start edges at cycles 5 and 20 -> output frame still A5 pattern; exactly one done pulse.
- DIV=1, sw=8'h81, repeat_en=1 -> frames 1,0,0,0,0,0,0,1 repeat with a 1-cycle done gap (period 9 cycles).
  - Clearing repeat_en mid-frame -> that frame completes, then IDLE.
- DIV=4, sw=8'hFF, reset asserted at cycle 10 of frame -> all outputs 0 in the same cycle; no done.
  - After release: IDLE, and a new start edge sends a full frame.
- DIV=3, sw=8'h01 -> serial_out 0 for 21 cycles, 1 for 3 cycles, then done. Confirms last-bit boundary and no extra bit.
